// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch bundle: the instruction-memory request/response channel
// and the one-entry instruction buffer handed to decode.
//   imem_req_valid/addr/ready : fetch request, valid/ready handshake
//   imem_resp_valid/data      : read data, one pulse per accepted request
//   if_valid/pc/instr/ready   : buffered instruction towards decode
// master = fetch controller side, slave = memory/decode side.
interface pc_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller.
// Holds the fetch PC, keeps at most one request outstanding to instruction
// memory, buffers each returned instruction for decode, and handles
// branch/jump redirects, traps, misaligned targets and squashing of
// in-flight responses. Counts accepted instructions (saturating).
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   boot_en        permits leaving IDLE
//   redirect_valid branch/jump taken this cycle, target redirect_pc
//   trap           trap request this cycle (wins over redirect_valid)
//   bus            memory channel + decode buffer (master modport)
//   current_pc     next address to fetch
//   misalign_err   one-cycle pulse after a misaligned redirect
//   fetch_count    accepted instructions, saturating at all-ones
module pc_fetch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              trap,
  pc_fetch_ctrl_if.master   bus,
  output logic [XLEN-1:0]   current_pc,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic              drop_reg, drop_next;
  logic              if_valid_reg, if_valid_next;
  logic [XLEN-1:0]   if_pc_reg, if_pc_next;
  logic [31:0]       if_instr_reg, if_instr_next;
  logic              misalign_reg, misalign_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic              redirect;
  logic              misaligned;
  logic [XLEN-1:0]   redirect_target;

  // Target selection: a trap or a misaligned branch both land on TRAP_VECTOR;
  // the error pulse is only raised when the branch itself was at fault.
  always_comb begin
    misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    redirect        = trap || redirect_valid;
    redirect_target = (trap || misaligned) ? TRAP_VECTOR : redirect_pc;
    misalign_next   = !trap && misaligned;
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    drop_next     = drop_reg;
    if_valid_next = if_valid_reg;
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;
    count_next    = count_reg;

    case (state_reg)
      S_IDLE: begin
        if (boot_en) state_next = S_REQ;
      end
      S_REQ: begin
        // A request accepted in a redirect cycle still carries the old
        // address, so its response must be thrown away.
        if (bus.imem_req_ready) begin
          state_next = S_WAIT;
          drop_next  = redirect;
        end
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          drop_next = 1'b0;
          if (drop_reg || redirect) begin
            state_next = S_REQ;
          end else begin
            if_pc_next    = pc_reg;
            if_instr_next = bus.imem_resp_data;
            if_valid_next = 1'b1;
            pc_next       = pc_reg + XLEN'(4);
            state_next    = S_OUT;
          end
        end else if (redirect) begin
          drop_next = 1'b1;
        end
      end
      S_OUT: begin
        // A redirect kills the buffered instruction even if decode is
        // taking it this cycle; such a hand-off is not counted.
        if (redirect) begin
          if_valid_next = 1'b0;
          state_next    = S_REQ;
        end else if (bus.if_ready) begin
          if_valid_next = 1'b0;
          state_next    = S_REQ;
          if (count_reg != {CNT_W{1'b1}}) count_next = count_reg + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (redirect) pc_next = redirect_target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_VECTOR;
      drop_reg     <= 1'b0;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= '0;
      if_instr_reg <= '0;
      misalign_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      drop_reg     <= drop_next;
      if_valid_reg <= if_valid_next;
      if_pc_reg    <= if_pc_next;
      if_instr_reg <= if_instr_next;
      misalign_reg <= misalign_next;
      count_reg    <= count_next;
    end
  end

  assign bus.imem_req_valid = (state_reg == S_REQ);
  assign bus.imem_req_addr  = pc_reg;
  assign bus.if_valid       = if_valid_reg;
  assign bus.if_pc          = if_pc_reg;
  assign bus.if_instr       = if_instr_reg;
  assign current_pc         = pc_reg;
  assign misalign_err       = misalign_reg;
  assign fetch_count        = count_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [31:0] TRAP_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        boot_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap = 1'b0;
  logic [31:0] current_pc;
  logic        misalign_err;
  logic [15:0] fetch_count;
  logic [31:0] current_pc2;
  logic        misalign_err2;
  logic [1:0]  fetch_count2;

  int passed = 0;
  int total = 0;
  int model_count = 0;
  logic [31:0] model_pc = '0;

  // memory model controls
  int   mem_lat = 0;
  bit   mem_ready_rand = 1'b0;
  bit   pend = 1'b0;
  int   pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  pc_fetch_ctrl_if #(.XLEN(32)) bus ();
  pc_fetch_ctrl_if #(.XLEN(32)) bus2 ();

  pc_fetch_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .boot_en(boot_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap(trap),
    .bus(bus), .current_pc(current_pc), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  // Narrow-counter copy fed with identical inputs, for saturation checks.
  pc_fetch_ctrl #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .boot_en(boot_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap(trap),
    .bus(bus2), .current_pc(current_pc2), .misalign_err(misalign_err2),
    .fetch_count(fetch_count2)
  );

  assign bus2.imem_req_ready  = bus.imem_req_ready;
  assign bus2.imem_resp_valid = bus.imem_resp_valid;
  assign bus2.imem_resp_data  = bus.imem_resp_data;
  assign bus2.if_ready        = bus.if_ready;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Instruction memory: one response per accepted request, mem_lat extra cycles.
  initial begin
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      if (reset && !pend && bus.imem_req_valid && bus.imem_req_ready) begin
        pend = 1'b1; pend_addr = bus.imem_req_addr; pend_cnt = mem_lat;
      end
      @(negedge clk);
      bus.imem_resp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          bus.imem_resp_valid = 1'b1; bus.imem_resp_data = mem_word(pend_addr); pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      bus.imem_req_ready = mem_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  // Waits for a buffered instruction and hands it to decode (one cycle of if_ready).
  task automatic take(output bit ok, output logic [31:0] pc, output logic [31:0] instr);
    ok = 1'b0; pc = 'x; instr = 'x;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.if_valid) begin
        ok = 1'b1; pc = bus.if_pc; instr = bus.if_instr; bus.if_ready = 1'b1;
      end
    end
    if (ok) begin
      $display("fetch pc=%h instr=%h count=%0d", pc, instr, model_count + 1);
      @(negedge clk);
      bus.if_ready = 1'b0;
      model_count++;
    end
  endtask

  task automatic pulse(input bit t, input bit rv, input logic [31:0] pc);
    trap = t; redirect_valid = rv; redirect_pc = pc;
    @(negedge clk);
    trap = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  task automatic test_reset();
    bus.if_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (current_pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", current_pc, 32'h0); else passed++;
    total++; if (bus.if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); else passed++;
    total++; if (bus.if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); else passed++;
    total++; if (bus.if_instr !== 32'h0) $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign_err); else passed++;
    total++; if (fetch_count !== 16'h0) $display("FAIL reset_count: got %0d want 0", fetch_count); else passed++;
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req_valid); else passed++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL idle_no_boot_req: got %b want 0", bus.imem_req_valid); else passed++;
  endtask

  task automatic test_boot();
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_if = 32'h0;
    int n = 0;
    boot_en = 1'b1; bus.if_ready = 1'b1; mem_lat = 0;
    for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
      @(negedge clk);
      if (bus.imem_req_valid && exp_req < 32'd12) begin
        total++; if (bus.imem_req_addr !== exp_req) $display("FAIL boot_req_addr: got %h want %h", bus.imem_req_addr, exp_req); else passed++;
        exp_req += 32'd4;
      end
      if (bus.if_valid) begin
        $display("fetch pc=%h instr=%h count=%0d", bus.if_pc, bus.if_instr, n + 1);
        total++; if (bus.if_pc !== exp_if) $display("FAIL boot_if_pc: got %h want %h", bus.if_pc, exp_if); else passed++;
        total++; if (bus.if_instr !== mem_word(exp_if)) $display("FAIL boot_if_instr: got %h want %h", bus.if_instr, mem_word(exp_if)); else passed++;
        exp_if += 32'd4;
        n++;
      end
    end
    total++; if (n != 3) $display("FAIL boot_timeout: got %0d deliveries want 3", n); else passed++;
    @(negedge clk);
    bus.if_ready = 1'b0;
    model_count = 3; model_pc = 32'hC;
    total++; if (fetch_count !== 16'd3) $display("FAIL boot_count: got %0d want 3", fetch_count); else passed++;
    total++; if (fetch_count2 !== 2'd3) $display("FAIL boot_count_w2: got %0d want 3", fetch_count2); else passed++;
  endtask

  task automatic test_back_pressure();
    bit ok; logic [31:0] pc, instr;
    for (int i = 0; i < 40 && !bus.if_valid; i++) @(negedge clk);
    total++; if (bus.if_valid !== 1'b1) $display("FAIL bp_timeout: got if_valid=%b want 1", bus.if_valid); else passed++;
    repeat (5) begin
      @(negedge clk);
      total++; if (bus.if_valid !== 1'b1) $display("FAIL bp_if_valid: got %b want 1", bus.if_valid); else passed++;
      total++; if (bus.if_pc !== model_pc) $display("FAIL bp_if_pc: got %h want %h", bus.if_pc, model_pc); else passed++;
      total++; if (bus.if_instr !== mem_word(model_pc)) $display("FAIL bp_if_instr: got %h want %h", bus.if_instr, mem_word(model_pc)); else passed++;
      total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL bp_no_req: got %b want 0", bus.imem_req_valid); else passed++;
      total++; if (current_pc !== model_pc + 32'd4) $display("FAIL bp_current_pc: got %h want %h", current_pc, model_pc + 32'd4); else passed++;
    end
    take(ok, pc, instr);
    total++; if (!ok) $display("FAIL bp_take_timeout: got none want pc %h", model_pc); else passed++;
    total++; if (pc !== model_pc) $display("FAIL bp_take_pc: got %h want %h", pc, model_pc); else passed++;
    model_pc += 32'd4;
    total++; if (fetch_count !== 16'(model_count)) $display("FAIL bp_count: got %0d want %0d", fetch_count, model_count); else passed++;
  endtask

  task automatic test_squash();
    bit ok; bit early = 1'b0; logic [31:0] pc, instr;
    mem_lat = 2;
    for (int i = 0; i < 40 && !bus.imem_req_valid; i++) @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b1) $display("FAIL squash_req_timeout: got %b want 1", bus.imem_req_valid); else passed++;
    @(negedge clk);
    pulse(1'b0, 1'b1, 32'h40);
    total++; if (current_pc !== 32'h40) $display("FAIL squash_pc: got %h want %h", current_pc, 32'h40); else passed++;
    for (int i = 0; i < 40 && !bus.imem_req_valid; i++) begin
      if (bus.if_valid) early = 1'b1;
      @(negedge clk);
    end
    total++; if (early || bus.if_valid) $display("FAIL squash_if_valid: got 1 want 0"); else passed++;
    total++; if (bus.imem_req_addr !== 32'h40 || !bus.imem_req_valid) $display("FAIL squash_next_req: got %h want %h", bus.imem_req_addr, 32'h40); else passed++;
    take(ok, pc, instr);
    total++; if (pc !== 32'h40) $display("FAIL squash_if_pc: got %h want %h", pc, 32'h40); else passed++;
    total++; if (instr !== mem_word(32'h40)) $display("FAIL squash_if_instr: got %h want %h", instr, mem_word(32'h40)); else passed++;
    total++; if (fetch_count !== 16'(model_count)) $display("FAIL squash_count: got %0d want %0d", fetch_count, model_count); else passed++;
  endtask

  task automatic test_trap_vs_branch();
    bit ok; logic [31:0] pc, instr;
    mem_lat = 1;
    pulse(1'b1, 1'b1, 32'h80);
    total++; if (current_pc !== TRAP_PC) $display("FAIL trap_pc: got %h want %h", current_pc, TRAP_PC); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL trap_misalign: got %b want 0", misalign_err); else passed++;
    take(ok, pc, instr);
    total++; if (pc !== TRAP_PC) $display("FAIL trap_if_pc: got %h want %h", pc, TRAP_PC); else passed++;
    total++; if (instr !== mem_word(TRAP_PC)) $display("FAIL trap_if_instr: got %h want %h", instr, mem_word(TRAP_PC)); else passed++;
  endtask

  task automatic test_misaligned();
    bit ok; logic [31:0] pc, instr;
    pulse(1'b0, 1'b1, 32'h42);
    total++; if (misalign_err !== 1'b1) $display("FAIL mis_pulse: got %b want 1", misalign_err); else passed++;
    total++; if (current_pc !== TRAP_PC) $display("FAIL mis_pc: got %h want %h", current_pc, TRAP_PC); else passed++;
    @(negedge clk);
    total++; if (misalign_err !== 1'b0) $display("FAIL mis_pulse_end: got %b want 0", misalign_err); else passed++;
    for (int i = 0; i < 40 && !bus.imem_req_valid; i++) @(negedge clk);
    total++; if (bus.imem_req_addr !== TRAP_PC || !bus.imem_req_valid) $display("FAIL mis_next_req: got %h want %h", bus.imem_req_addr, TRAP_PC); else passed++;
    take(ok, pc, instr);
    total++; if (pc !== TRAP_PC) $display("FAIL mis_if_pc: got %h want %h", pc, TRAP_PC); else passed++;
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] pc, instr;
    pulse(1'b0, 1'b1, 32'hFFFF_FFFC);
    take(ok, pc, instr);
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_if_pc: got %h want %h", pc, 32'hFFFF_FFFC); else passed++;
    total++; if (current_pc !== 32'h0) $display("FAIL wrap_current_pc: got %h want 0", current_pc); else passed++;
    take(ok, pc, instr);
    total++; if (pc !== 32'h0) $display("FAIL wrap_next_pc: got %h want 0", pc); else passed++;
    total++; if (instr !== mem_word(32'h0)) $display("FAIL wrap_next_instr: got %h want %h", instr, mem_word(32'h0)); else passed++;
  endtask

  task automatic test_random();
    int got = 0; int r; bit exp_mis = 1'b0; bit t, rv, rdy; logic [31:0] rpc;
    mem_ready_rand = 1'b1;
    pulse(1'b0, 1'b1, 32'h1000);
    model_pc = 32'h1000;
    for (int cyc = 0; cyc < 4000 && got < 40; cyc++) begin
      total++; if (misalign_err !== exp_mis) $display("FAIL rand_misalign: got %b want %b", misalign_err, exp_mis); else passed++;
      r = $urandom_range(0, 39);
      t = 1'b0; rv = 1'b0; rpc = '0;
      rdy = 1'($urandom_range(0, 1));
      if (r == 0) begin
        t = 1'b1; rv = 1'($urandom_range(0, 1)); rpc = 32'($urandom_range(0, 1023));
      end else if (r == 1) begin
        rv = 1'b1; rpc = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      end else if (r == 2) begin
        rv = 1'b1; rpc = 32'($urandom_range(0, 255)) << 2;
      end
      if (bus.if_valid && rdy && !(t || rv)) begin
        $display("fetch pc=%h instr=%h count=%0d", bus.if_pc, bus.if_instr, model_count + 1);
        total++; if (bus.if_pc !== model_pc) $display("FAIL rand_if_pc: got %h want %h", bus.if_pc, model_pc); else passed++;
        total++; if (bus.if_instr !== mem_word(model_pc)) $display("FAIL rand_if_instr: got %h want %h", bus.if_instr, mem_word(model_pc)); else passed++;
        model_pc += 32'd4; model_count++; got++;
      end
      if (t || rv) model_pc = (t || rpc[1:0] != 2'b00) ? TRAP_PC : rpc;
      exp_mis = !t && rv && (rpc[1:0] != 2'b00);
      trap = t; redirect_valid = rv; redirect_pc = rpc; bus.if_ready = rdy;
      mem_lat = $urandom_range(0, 3);
      @(negedge clk);
    end
    trap = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; bus.if_ready = 1'b0;
    mem_ready_rand = 1'b0;
    total++; if (got != 40) $display("FAIL rand_timeout: got %0d deliveries want 40", got); else passed++;
    total++; if (misalign_err !== exp_mis) $display("FAIL rand_misalign_last: got %b want %b", misalign_err, exp_mis); else passed++;
    total++; if (fetch_count !== 16'(model_count)) $display("FAIL rand_count: got %0d want %0d", fetch_count, model_count); else passed++;
    total++; if (fetch_count2 !== ((model_count > 3) ? 2'd3 : 2'(model_count))) $display("FAIL rand_count_sat: got %0d want 3", fetch_count2); else passed++;
  endtask

  task automatic test_async_reset();
    bit ok; logic [31:0] pc, instr;
    mem_lat = 3;
    @(negedge clk);
    pulse(1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 40 && !bus.imem_req_valid; i++) @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0; boot_en = 1'b0;
    #1;
    total++; if (current_pc !== 32'h0) $display("FAIL areset_pc: got %h want 0", current_pc); else passed++;
    total++; if (bus.if_valid !== 1'b0) $display("FAIL areset_if_valid: got %b want 0", bus.if_valid); else passed++;
    total++; if (bus.if_pc !== 32'h0) $display("FAIL areset_if_pc: got %h want 0", bus.if_pc); else passed++;
    total++; if (bus.if_instr !== 32'h0) $display("FAIL areset_if_instr: got %h want 0", bus.if_instr); else passed++;
    total++; if (fetch_count !== 16'h0) $display("FAIL areset_count: got %0d want 0", fetch_count); else passed++;
    total++; if (fetch_count2 !== 2'h0) $display("FAIL areset_count_w2: got %0d want 0", fetch_count2); else passed++;
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL areset_req: got %b want 0", bus.imem_req_valid); else passed++;
    total++; if (misalign_err !== 1'b0) $display("FAIL areset_misalign: got %b want 0", misalign_err); else passed++;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    model_count = 0;
    repeat (3) begin
      @(negedge clk);
      total++; if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) $display("FAIL areset_idle: got if_valid=%b req=%b want 0/0", bus.if_valid, bus.imem_req_valid); else passed++;
    end
    mem_lat = 0; boot_en = 1'b1;
    take(ok, pc, instr);
    total++; if (pc !== 32'h0) $display("FAIL reboot_pc: got %h want 0", pc); else passed++;
    total++; if (instr !== mem_word(32'h0)) $display("FAIL reboot_instr: got %h want %h", instr, mem_word(32'h0)); else passed++;
    total++; if (fetch_count !== 16'd1) $display("FAIL reboot_count: got %0d want 1", fetch_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_back_pressure();
    test_squash();
    test_trap_vs_branch();
    test_misaligned();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
